spi_txn_arbiter: RTL and testbench
==================================

// Module: spi_txn_arbiter
// PURPOSE
//  Shares one SPI master transmit engine between N_REQ requesters, e.g. the counter-update
//  path and the clear/command path. Only one frame is in flight at a time.
//  Round-robin arbitration; the winner's word is latched, the engine is started, and the
//  engine's completion is returned to the owner. A watchdog timeout recovers from a hung engine.
//  Sits between the counter/control logic and the SPI master core, on the master side.
// PARAMETERS
//  N_REQ    2     number of requesters (>=2)
//  DATA_W   14    frame payload width (matches counter width)
//  TIMEOUT  1023  max cycles in WAIT_DONE before abort (>=4)
// PORTS
//  clk          in   1             system clock (100 MHz); the only clock
//  reset        in   1             synchronous, active-low reset
//  i_req        in   N_REQ         per-requester level request, held until granted
//  i_data       in   N_REQ*DATA_W  payload; slice k = i_data[k*DATA_W +: DATA_W]
//  o_gnt        out  N_REQ         one-hot 1-cycle pulse: request k accepted, data latched
//  o_done       out  N_REQ         one-hot 1-cycle pulse: frame for k completed
//  o_spi_start  out  1             1-cycle start pulse to SPI engine
//  o_spi_data   out  DATA_W        latched payload, stable from grant until return to IDLE
//  i_spi_busy   in   1             engine busy level
//  i_spi_done   in   1             engine 1-cycle completion pulse
//  o_busy       out  1             arbiter not in IDLE
//  o_timeout    out  1             1-cycle pulse: frame aborted by watchdog
//  o_owner      out  $clog2(N_REQ) index of current/last owner
// BEHAVIOUR
//  - One clock; reset is synchronous and active-low. All outputs are registered.
//  - Reset (reset==0 at a clk edge):
//    - state=IDLE, rr pointer=0, timer=0.
//    - o_gnt, o_done, o_spi_start, o_timeout, o_busy = 0; o_spi_data=0; o_owner=0.
//    - Applies mid-frame too: no o_done or o_timeout is emitted for the killed frame.
//  - FSM states: IDLE, ISSUE, WAIT_DONE.
//    - IDLE: if |i_req && !i_spi_busy, pick the winner k (see arbitration).
//      Next edge: o_gnt[k]=1, o_spi_data=i_data slice k, o_owner=k, o_busy=1, state ISSUE.
//      If i_spi_busy=1, no grant; requests wait.
//    - ISSUE: o_spi_start=1 for exactly this cycle; timer cleared; state WAIT_DONE.
//    - WAIT_DONE: timer increments each cycle.
//      - i_spi_done=1: o_done[owner]=1 next cycle, rr pointer=owner+1 mod N_REQ, state IDLE.
//      - timer==TIMEOUT-1 without done: o_timeout=1 next cycle, no o_done, pointer advances
//        as for done, state IDLE.
//      - done and timeout in the same cycle: done wins, no o_timeout.
//  - Arbitration: scan from rr pointer upward with wrap; the first asserted i_req wins.
//    After reset requester 0 has priority.
//  - Latency, request to first engine action: request at IDLE edge t -> o_gnt at t+1
//    -> o_spi_start at t+2.
//  - Latency, completion: i_spi_done sampled at edge d -> o_done at d+1.
//    Earliest next grant is at d+2 (IDLE must sample the requests).
//  - Input sampling rules:
//    - i_spi_done is ignored outside WAIT_DONE.
//    - i_req deasserting after o_gnt does not cancel the frame.
//    - i_req changes during a frame have no effect until IDLE.
//    - i_data of the owner is sampled only at grant.
//  - Output pulse rules: o_gnt and o_done are never multi-hot; at most one frame is outstanding.
//  - Timer is $clog2(TIMEOUT+1) bits wide and cannot wrap, because the watchdog fires first.
// TESTING
//  1. Reset: hold reset=0 for 3 cycles with i_req=2'b11 -> all pulses 0, o_busy=0,
//     o_spi_data=0; release -> o_gnt=2'b01 one cycle later.
//  2. Single frame: req0, data0=14'h1234, done returned 5 cycles after start
//     -> o_spi_data=14'h1234, one o_spi_start pulse, o_done=2'b01.
//  3. Fairness: i_req=2'b11 held continuously for 4 frames -> grant order 0,1,0,1.
//  4. Busy block: i_spi_busy=1 in IDLE with req1 -> no o_gnt.
//     Deassert busy -> o_gnt=2'b10 next cycle.
//  5. Watchdog: TIMEOUT=8, never assert done -> o_timeout pulse, no o_done, o_busy=0.
//     Next grant goes to the other requester.
//  6. Corner cases:
//     - Done coincident with the last timer cycle -> o_done only.
//     - reset=0 asserted in WAIT_DONE -> no o_done or o_timeout, state IDLE.

Source files
------------

// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter that shares one SPI transmit engine between N_REQ requesters,
// with a watchdog that abandons a frame if the engine never reports completion.
module spi_txn_arbiter #(
  parameter int N_REQ   = 2,
  parameter int DATA_W  = 14,
  parameter int TIMEOUT = 1023
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         i_req,
  input  logic [N_REQ*DATA_W-1:0]  i_data,
  output logic [N_REQ-1:0]         o_gnt,
  output logic [N_REQ-1:0]         o_done,
  output logic                     o_spi_start,
  output logic [DATA_W-1:0]        o_spi_data,
  input  logic                     i_spi_busy,
  input  logic                     i_spi_done,
  output logic                     o_busy,
  output logic                     o_timeout,
  output logic [$clog2(N_REQ)-1:0] o_owner
);

  localparam int OW = $clog2(N_REQ);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

  state_t            state, state_nxt;
  logic [OW-1:0]     ptr, ptr_nxt, ptr_adv;
  logic [TW-1:0]     timer, timer_nxt;
  logic [N_REQ-1:0]  req_rot;
  logic [OW:0]       win_sum;
  logic [OW-1:0]     win;
  logic              win_vld;
  logic              expire;

  logic [N_REQ-1:0]  gnt_nxt, done_nxt;
  logic              start_nxt, timeout_nxt, busy_nxt;
  logic [DATA_W-1:0] data_nxt;
  logic [OW-1:0]     owner_nxt;

  // Rotate requests so bit 0 is the requester at the rr pointer; lowest set bit wins.
  always_comb begin : arbitrate
    req_rot = N_REQ'({i_req, i_req} >> ptr);
    win_vld = 1'b0;
    win_sum = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        win_vld = 1'b1;
        win_sum = {1'b0, ptr} + (OW+1)'(k);
      end
    end
    if (win_sum >= (OW+1)'(N_REQ)) win_sum = win_sum - (OW+1)'(N_REQ);
    win = win_sum[OW-1:0];
  end

  assign expire  = (timer == TLAST);
  assign ptr_adv = (o_owner == OW'(N_REQ - 1)) ? '0 : o_owner + 1'b1;

  always_comb begin : next_state
    state_nxt = state;
    case (state)
      IDLE:      if (win_vld && !i_spi_busy) state_nxt = ISSUE;
      ISSUE:     state_nxt = WAIT_DONE;
      WAIT_DONE: if (i_spi_done || expire) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin : outputs
    gnt_nxt     = '0;
    done_nxt    = '0;
    start_nxt   = 1'b0;
    timeout_nxt = 1'b0;
    data_nxt    = o_spi_data;
    owner_nxt   = o_owner;
    ptr_nxt     = ptr;
    timer_nxt   = timer;
    case (state)
      IDLE: begin
        if (win_vld && !i_spi_busy) begin
          gnt_nxt   = N_REQ'(1) << win;
          data_nxt  = i_data[int'(win)*DATA_W +: DATA_W];
          owner_nxt = win;
        end
      end
      ISSUE: begin
        start_nxt = 1'b1;
        timer_nxt = '0;
      end
      WAIT_DONE: begin
        timer_nxt = timer + 1'b1;
        // Done takes precedence over a watchdog expiry landing on the same cycle.
        if (i_spi_done) begin
          done_nxt = N_REQ'(1) << o_owner;
          ptr_nxt  = ptr_adv;
        end else if (expire) begin
          timeout_nxt = 1'b1;
          ptr_nxt     = ptr_adv;
        end
      end
      default: ;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin : state_reg
    if (!reset) begin
      state       <= IDLE;
      ptr         <= '0;
      timer       <= '0;
      o_gnt       <= '0;
      o_done      <= '0;
      o_spi_start <= 1'b0;
      o_timeout   <= 1'b0;
      o_busy      <= 1'b0;
      o_spi_data  <= '0;
      o_owner     <= '0;
    end else begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      timer       <= timer_nxt;
      o_gnt       <= gnt_nxt;
      o_done      <= done_nxt;
      o_spi_start <= start_nxt;
      o_timeout   <= timeout_nxt;
      o_busy      <= busy_nxt;
      o_spi_data  <= data_nxt;
      o_owner     <= owner_nxt;
    end
  end

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Directed bench for spi_txn_arbiter: expected grants are queued as requests are driven
// and popped when a grant appears; a negedge monitor tracks pulses and one-hot rules.
module tb_spi_txn_arbiter;

  localparam int N_REQ   = 2;
  localparam int DATA_W  = 14;
  localparam int TIMEOUT = 8;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [N_REQ-1:0]        i_req;
  logic [N_REQ*DATA_W-1:0] i_data;
  logic [N_REQ-1:0]        o_gnt, o_done;
  logic                    o_spi_start, o_busy, o_timeout;
  logic [DATA_W-1:0]       o_spi_data;
  logic                    i_spi_busy, i_spi_done;
  logic [0:0]              o_owner;

  spi_txn_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .i_req(i_req), .i_data(i_data),
    .o_gnt(o_gnt), .o_done(o_done), .o_spi_start(o_spi_start), .o_spi_data(o_spi_data),
    .i_spi_busy(i_spi_busy), .i_spi_done(i_spi_done), .o_busy(o_busy),
    .o_timeout(o_timeout), .o_owner(o_owner)
  );

  always #5 clk = ~clk;

  typedef struct { logic [1:0] oh; logic [13:0] data; } exp_t;
  exp_t sb[$];

  int checks = 0;
  int failures = 0;
  int start_cnt = 0, done_cnt = 0, to_cnt = 0;
  logic [1:0] cur_oh = 2'b00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (o_spi_start === 1'b1) start_cnt++;
    if (o_done !== 2'b00) done_cnt++;
    if (o_timeout === 1'b1) to_cnt++;
    check("onehot_pulses", {31'd0, $onehot0(o_gnt) && $onehot0(o_done)}, 32'd1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] oh, input logic [13:0] data);
    exp_t e;
    e.oh = oh;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic wait_gnt(input int budget);
    int n;
    exp_t e;
    n = 0;
    do begin
      step();
      n++;
    end while (o_gnt == 2'b00 && n < budget);
    check("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      cur_oh = e.oh;
      check("gnt", {30'd0, o_gnt}, {30'd0, e.oh});
      check("spi_data", {18'd0, o_spi_data}, {18'd0, e.data});
      check("owner", {31'd0, o_owner}, {31'd0, e.oh == 2'b10});
      check("busy_at_gnt", {31'd0, o_busy}, 32'd1);
    end
  endtask

  // Engine samples done 'delay' edges after the edge that raised o_spi_start.
  task automatic run_frame(input int delay);
    step();
    check("spi_start", {31'd0, o_spi_start}, 32'd1);
    for (int i = 0; i < delay - 1; i++) begin
      step();
      check("no_early_done", {30'd0, o_done, o_timeout}, 32'd0);
    end
    i_spi_done = 1'b1;
    step();
    i_spi_done = 1'b0;
    check("done", {30'd0, o_done}, {30'd0, cur_oh});
    check("no_timeout", {31'd0, o_timeout}, 32'd0);
    check("idle_after_done", {31'd0, o_busy}, 32'd0);
  endtask

  initial begin
    int s0, d0, t0;
    reset = 1'b0;
    i_req = 2'b11;
    i_data = {14'h0555, 14'h0AAA};
    i_spi_busy = 1'b0;
    i_spi_done = 1'b0;

    // Reset held with both requesters active
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_outs", {o_gnt, o_done, o_spi_start, o_timeout, o_busy, o_owner}, 32'd0);
      check("rst_data", {18'd0, o_spi_data}, 32'd0);
    end
    reset = 1'b1;
    push(2'b01, 14'h0AAA);
    wait_gnt(1);
    run_frame(3);

    // Single frame from requester 0
    i_req = 2'b01;
    i_data = {14'h0555, 14'h1234};
    s0 = start_cnt;
    push(2'b01, 14'h1234);
    wait_gnt(1);
    run_frame(5);
    check("one_start", start_cnt - s0, 32'd1);
    reset = 1'b0;
    step();
    reset = 1'b1;

    // Fairness with both requests held
    i_req = 2'b11;
    i_data = {14'h0BBB, 14'h0CCC};
    push(2'b01, 14'h0CCC);
    push(2'b10, 14'h0BBB);
    push(2'b01, 14'h0CCC);
    push(2'b10, 14'h0BBB);
    for (int f = 0; f < 4; f++) begin
      wait_gnt(3);
      run_frame(2);
    end

    // Engine busy blocks granting
    i_req = 2'b10;
    i_spi_busy = 1'b1;
    i_data = {14'h2BCD, 14'h0CCC};
    for (int i = 0; i < 4; i++) begin
      step();
      check("busy_block", {29'd0, o_gnt, o_busy}, 32'd0);
    end
    i_spi_busy = 1'b0;
    push(2'b10, 14'h2BCD);
    wait_gnt(1);
    run_frame(4);

    // Watchdog expiry, request and data changes during the frame are ignored
    i_req = 2'b01;
    i_data = {14'h2BCD, 14'h0111};
    push(2'b01, 14'h0111);
    wait_gnt(1);
    i_req = 2'b00;
    i_data = {14'h3333, 14'h3FFF};
    step();
    check("wd_start", {31'd0, o_spi_start}, 32'd1);
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      step();
      check("wd_wait", {30'd0, o_done, o_timeout}, 32'd0);
      check("wd_busy", {31'd0, o_busy}, 32'd1);
      check("wd_data_hold", {18'd0, o_spi_data}, 32'h0111);
    end
    step();
    check("wd_timeout", {31'd0, o_timeout}, 32'd1);
    check("wd_no_done", {30'd0, o_done}, 32'd0);
    check("wd_idle", {31'd0, o_busy}, 32'd0);
    i_req = 2'b11;
    push(2'b10, 14'h3333);
    wait_gnt(1);
    // Done on the final watchdog cycle
    run_frame(TIMEOUT);

    // Reset while waiting for done
    i_req = 2'b01;
    push(2'b01, 14'h3FFF);
    wait_gnt(2);
    i_req = 2'b00;
    step();
    step();
    step();
    d0 = done_cnt;
    t0 = to_cnt;
    reset = 1'b0;
    step();
    check("midrst_outs", {o_gnt, o_done, o_spi_start, o_timeout, o_busy, o_owner}, 32'd0);
    check("midrst_data", {18'd0, o_spi_data}, 32'd0);
    reset = 1'b1;
    i_spi_done = 1'b1;
    step();
    i_spi_done = 1'b0;
    for (int i = 0; i < 12; i++) step();
    check("midrst_no_done", done_cnt - d0, 32'd0);
    check("midrst_no_timeout", to_cnt - t0, 32'd0);
    check("midrst_idle", {31'd0, o_busy}, 32'd0);
    check("sb_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
